// File: rtl/sync_carrier_pkg.sv
// Shared types and constants for the sync carrier generator.
// Optional build macro SYNC_UPDOWN_EN selects centre-aligned (triangle) carriers.
package sync_carrier_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  localparam int MIN_PERIOD    = 2;
  localparam int DEF_BITS_DATA = 16;

  // Saturate a phase offset so it never exceeds the terminal count.
  function automatic logic [31:0] clamp_phase(input logic [31:0] phase,
                                              input logic [31:0] f);
    return (phase > f) ? f : phase;
  endfunction

endpackage

// File: rtl/sync_carrier_gen_counter.sv
// One carrier channel: counter, terminal compare and registered sync pulse.
// With SYNC_UPDOWN_EN defined the counter runs up/down with a direction bit;
// otherwise it is a plain sawtooth and no direction logic exists.
module sync_phase_counter
  import sync_carrier_pkg::*;
#(
  parameter int BITS_DATA = DEF_BITS_DATA
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 run,
  input  logic                 load,
  input  logic [BITS_DATA-1:0] load_val,
  input  logic [BITS_DATA-1:0] load_f,
  input  logic [BITS_DATA-1:0] f,
  output logic [BITS_DATA-1:0] cnt,
  output logic                 sync
);

  localparam logic [BITS_DATA-1:0] ONE = BITS_DATA'(1);

  logic [BITS_DATA-1:0] cnt_nxt;
  logic [BITS_DATA-1:0] f_nxt;
  logic                 live;

`ifdef SYNC_UPDOWN_EN
  logic dir_up;
  logic dir_nxt;

  // Next count for the triangle carrier: up to F, then down to 0.
  always_comb begin
    cnt_nxt = '0;
    dir_nxt = 1'b1;
    if (load) begin
      cnt_nxt = load_val;
    end else if (!run) begin
      cnt_nxt = '0;
    end else if (dir_up) begin
      if (cnt == f) begin
        cnt_nxt = f - ONE;
        dir_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt + ONE;
      end
    end else if (cnt <= ONE) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt - ONE;
      dir_nxt = 1'b0;
    end
  end
`else
  // Next count for the sawtooth carrier: wrap to 0 after F.
  always_comb begin
    cnt_nxt = '0;
    if (load) begin
      cnt_nxt = load_val;
    end else if (run) begin
      cnt_nxt = (cnt == f) ? '0 : cnt + ONE;
    end
  end
`endif

  // A load brings a new terminal count with it, so compare against that.
  assign f_nxt = load ? load_f : f;
  assign live  = load | run;

  // Register count and the sync pulse aligned with count == F.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt    <= '0;
      sync   <= 1'b0;
`ifdef SYNC_UPDOWN_EN
      dir_up <= 1'b1;
`endif
    end else begin
      cnt    <= cnt_nxt;
      sync   <= live && (cnt_nxt == f_nxt);
`ifdef SYNC_UPDOWN_EN
      dir_up <= dir_nxt;
`endif
    end
  end

endmodule

// File: rtl/sync_carrier_gen.sv
// Multi-channel synchronisation carrier generator: master counter, shadow
// registers, load FSM and per-channel phase counters.
// Optional build macro SYNC_UPDOWN_EN selects centre-aligned carriers.
module sync_carrier_gen
  import sync_carrier_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int BITS_DATA = DEF_BITS_DATA
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          iEN,
  input  logic [BITS_DATA-1:0]          iFREQUENCY,
  input  logic [CHANNELS*BITS_DATA-1:0] iPHASE,
  input  logic                          iLOAD,
  output logic                          oLOAD_ACK,
  output logic [CHANNELS*BITS_DATA-1:0] oCNT,
  output logic [CHANNELS-1:0]           oSYNC,
  output logic                          oBUSY
);

  localparam int CW = CHANNELS * BITS_DATA;
  localparam logic [BITS_DATA-1:0] F_MIN = BITS_DATA'(MIN_PERIOD);
  localparam logic [BITS_DATA-1:0] ONE   = BITS_DATA'(1);

  state_t               state;
  logic [BITS_DATA-1:0] f_act;
  logic [BITS_DATA-1:0] sh_f;
  logic [BITS_DATA-1:0] f_req;
  logic [CW-1:0]        ph_act;
  logic [CW-1:0]        sh_ph;
  logic [CW-1:0]        ph_req;
  logic [CW-1:0]        ld_ph;
  logic [BITS_DATA-1:0] ld_f;
  logic [BITS_DATA-1:0] m_cnt;
  logic                 at_bound;
  logic                 start;
  logic                 apply;
  logic                 ld;
  logic                 use_sh;
  logic                 run;

  // Range-limit requested settings before they reach the shadow registers.
  always_comb begin
    f_req  = (iFREQUENCY < F_MIN) ? F_MIN : iFREQUENCY;
    ph_req = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      ph_req[k*BITS_DATA +: BITS_DATA] =
        BITS_DATA'(clamp_phase(32'(iPHASE[k*BITS_DATA +: BITS_DATA]), 32'(f_req)));
    end
  end

  // Load strobes: start from IDLE, or apply a pending load at the period boundary.
  always_comb begin
    start  = (state == IDLE) && iEN;
    apply  = (state == PENDING) && iEN && at_bound;
    ld     = start || apply;
    use_sh = apply || (start && oBUSY);
    ld_f   = use_sh ? sh_f : f_act;
    ld_ph  = use_sh ? sh_ph : ph_act;
    run    = iEN && (state != IDLE);
  end

`ifdef SYNC_UPDOWN_EN
  logic m_dir_up;

  // Master triangle counter; the period ends as it returns to 0.
  always_ff @(posedge CLK) begin
    if (RST || ld || !run) begin
      m_cnt    <= '0;
      m_dir_up <= 1'b1;
    end else if (m_dir_up) begin
      if (m_cnt == f_act) begin
        m_cnt    <= f_act - ONE;
        m_dir_up <= 1'b0;
      end else begin
        m_cnt <= m_cnt + ONE;
      end
    end else if (m_cnt <= ONE) begin
      m_cnt    <= '0;
      m_dir_up <= 1'b1;
    end else begin
      m_cnt <= m_cnt - ONE;
    end
  end

  assign at_bound = !m_dir_up && (m_cnt == ONE);
`else
  // Master sawtooth counter; the period ends at count F.
  always_ff @(posedge CLK) begin
    if (RST || ld || !run) begin
      m_cnt <= '0;
    end else begin
      m_cnt <= (m_cnt == f_act) ? '0 : m_cnt + ONE;
    end
  end

  assign at_bound = (m_cnt == f_act);
`endif

  // Load FSM with shadow capture, active settings and ack/busy flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      f_act     <= F_MIN;
      ph_act    <= '0;
      sh_f      <= '0;
      sh_ph     <= '0;
      oBUSY     <= 1'b0;
      oLOAD_ACK <= 1'b0;
    end else begin
      oLOAD_ACK <= ld && use_sh;
      if (ld) begin
        f_act  <= ld_f;
        ph_act <= ld_ph;
      end
      // A capture on the apply edge stays pending; the old shadow is applied.
      if (iLOAD) begin
        sh_f  <= f_req;
        sh_ph <= ph_req;
        oBUSY <= 1'b1;
      end else if (ld && use_sh) begin
        oBUSY <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (iEN) state <= iLOAD ? PENDING : RUN;
        end
        RUN: begin
          if (!iEN)       state <= IDLE;
          else if (iLOAD) state <= PENDING;
        end
        PENDING: begin
          if (!iEN)                 state <= IDLE;
          else if (apply && !iLOAD) state <= RUN;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    sync_phase_counter #(
      .BITS_DATA(BITS_DATA)
    ) u_cnt (
      .CLK     (CLK),
      .RST     (RST),
      .run     (run),
      .load    (ld),
      .load_val(ld_ph[k*BITS_DATA +: BITS_DATA]),
      .load_f  (ld_f),
      .f       (f_act),
      .cnt     (oCNT[k*BITS_DATA +: BITS_DATA]),
      .sync    (oSYNC[k])
    );
  end

endmodule

// File: tb/tb_sync_carrier_gen.sv
// Directed bench for sync_carrier_gen (CHANNELS=2, BITS_DATA=16).
// Build with SYNC_UPDOWN_EN to exercise the centre-aligned carrier instead.
module tb_sync_carrier_gen;

  localparam int BD = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iEN;
  logic [15:0] iFREQUENCY;
  logic [31:0] iPHASE;
  logic        iLOAD;
  logic        oLOAD_ACK;
  logic [31:0] oCNT;
  logic [1:0]  oSYNC;
  logic        oBUSY;

  int total = 0;
  int bad = 0;
  int ack_seen = 0;
  int n;

  sync_carrier_gen #(.CHANNELS(2), .BITS_DATA(BD)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .iEN       (iEN),
    .iFREQUENCY(iFREQUENCY),
    .iPHASE    (iPHASE),
    .iLOAD     (iLOAD),
    .oLOAD_ACK (oLOAD_ACK),
    .oCNT      (oCNT),
    .oSYNC     (oSYNC),
    .oBUSY     (oBUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cnt_of(input int k);
    return oCNT[k*BD +: BD];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    if (oLOAD_ACK) ack_seen++;
  endtask

  task automatic wait_sync(input int ch, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (oSYNC[ch]) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (oLOAD_ACK) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic wait_cnt0(input logic [15:0] value, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (cnt_of(0) == value) begin
        cycles = i;
        break;
      end
    end
  endtask

  initial begin
    RST = 1'b1; iEN = 1'b0; iLOAD = 1'b0; iFREQUENCY = 16'd0; iPHASE = 32'd0;
    tick(); tick(); tick();
    check_val("rst_cnt", oCNT, 32'd0);
    check_val("rst_sync", {30'd0, oSYNC}, 32'd0);
    check_val("rst_busy", {31'd0, oBUSY}, 32'd0);
    check_val("rst_ack", {31'd0, oLOAD_ACK}, 32'd0);
    RST = 1'b0;
    tick();

`ifdef SYNC_UPDOWN_EN
    // Triangle carrier, F=10, phase 0: 0..10..0, sync at the peak only.
    iFREQUENCY = 16'd10; iPHASE = 32'd0; iLOAD = 1'b1;
    tick();
    iLOAD = 1'b0; iEN = 1'b1;
    tick();
    check_val("ud_ack", {31'd0, oLOAD_ACK}, 32'd1);
    for (int i = 0; i <= 40; i++) begin
      int e;
      int tri_v;
      if (i > 0) tick();
      e = i % 20;
      tri_v = (e <= 10) ? e : 20 - e;
      check_val("ud_cnt", {16'd0, cnt_of(0)}, tri_v);
      check_val("ud_sync", {31'd0, oSYNC[0]}, (tri_v == 10) ? 32'd1 : 32'd0);
    end
`else
    // F below minimum and phase above F: clamped to F=2, phase 2.
    iFREQUENCY = 16'd0; iPHASE = {16'd0, 16'd9}; iLOAD = 1'b1;
    tick();
    iLOAD = 1'b0;
    check_val("clamp_busy", {31'd0, oBUSY}, 32'd1);
    check_val("clamp_idle_ack", {31'd0, oLOAD_ACK}, 32'd0);
    iEN = 1'b1;
    tick();
    check_val("clamp_ack", {31'd0, oLOAD_ACK}, 32'd1);
    check_val("clamp_busy_clr", {31'd0, oBUSY}, 32'd0);
    check_val("clamp_cnt0", {16'd0, cnt_of(0)}, 32'd2);
    check_val("clamp_cnt1", {16'd0, cnt_of(1)}, 32'd0);
    check_val("clamp_sync_a", {30'd0, oSYNC}, 32'd1);
    tick();
    check_val("clamp_wrap0", {16'd0, cnt_of(0)}, 32'd0);
    check_val("clamp_sync_b", {30'd0, oSYNC}, 32'd0);
    tick();
    check_val("clamp_sync_c", {30'd0, oSYNC}, 32'd2);
    tick();
    check_val("clamp_sync_d", {30'd0, oSYNC}, 32'd1);
    iEN = 1'b0;
    tick();
    check_val("idle_cnt", oCNT, 32'd0);
    check_val("idle_sync", {30'd0, oSYNC}, 32'd0);

    // F=4000, phases {0,2000}.
    iFREQUENCY = 16'd4000; iPHASE = {16'd2000, 16'd0}; iLOAD = 1'b1;
    tick();
    iLOAD = 1'b0; iEN = 1'b1;
    tick();
    check_val("p4k_ack", {31'd0, oLOAD_ACK}, 32'd1);
    check_val("p4k_cnt1", {16'd0, cnt_of(1)}, 32'd2000);
    wait_sync(1, 5000, n); check_val("p4k_first_s1", n, 32'd2000);
    wait_sync(0, 5000, n); check_val("p4k_first_s0", n, 32'd2000);
    wait_sync(1, 5000, n); check_val("p4k_next_s1", n, 32'd2001);
    wait_sync(0, 5000, n); check_val("p4k_next_s0", n, 32'd2000);

    // Reload to F=1000 at master count 100: old period finishes first.
    wait_cnt0(16'd100, 5000, n); check_val("reach_100", {31'd0, (n >= 0)}, 32'd1);
    iFREQUENCY = 16'd1000; iPHASE = {16'd500, 16'd0}; iLOAD = 1'b1;
    tick();
    iLOAD = 1'b0;
    check_val("rl_busy", {31'd0, oBUSY}, 32'd1);
    check_val("rl_noack", {31'd0, oLOAD_ACK}, 32'd0);
    wait_sync(0, 5000, n); check_val("rl_old_end", n, 32'd3899);
    check_val("rl_busy_hold", {31'd0, oBUSY}, 32'd1);
    tick();
    check_val("rl_ack", {31'd0, oLOAD_ACK}, 32'd1);
    check_val("rl_busy_clr", {31'd0, oBUSY}, 32'd0);
    check_val("rl_cnt0", {16'd0, cnt_of(0)}, 32'd0);
    check_val("rl_cnt1", {16'd0, cnt_of(1)}, 32'd500);
    wait_sync(0, 2000, n); check_val("rl_new_s0", n, 32'd1000);
    wait_sync(0, 2000, n); check_val("rl_new_period", n, 32'd1001);

    // Two loads in one period: single ack, last write wins.
    iFREQUENCY = 16'd500; iPHASE = 32'd0; iLOAD = 1'b1;
    tick();
    iLOAD = 1'b0;
    check_val("dbl_wrap_noack", {31'd0, oLOAD_ACK}, 32'd0);
    check_val("dbl_busy", {31'd0, oBUSY}, 32'd1);
    for (int i = 0; i < 10; i++) tick();
    iFREQUENCY = 16'd700; iPHASE = {16'd100, 16'd0}; iLOAD = 1'b1;
    tick();
    iLOAD = 1'b0;
    wait_ack(2000, n); check_val("dbl_ack_at", n, 32'd990);
    check_val("dbl_cnt1", {16'd0, cnt_of(1)}, 32'd100);
    ack_seen = 0;
    wait_sync(0, 2000, n); check_val("dbl_s0", n, 32'd700);
    wait_sync(0, 2000, n); check_val("dbl_period", n, 32'd701);
    check_val("dbl_single_ack", ack_seen, 32'd0);
    check_val("dbl_busy_clr", {31'd0, oBUSY}, 32'd0);

    // Reset while a load is pending: everything cleared, load lost.
    iFREQUENCY = 16'd300; iPHASE = 32'd0; iLOAD = 1'b1;
    tick();
    iLOAD = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_val("rp_busy", {31'd0, oBUSY}, 32'd1);
    RST = 1'b1;
    tick();
    check_val("rp_cnt", oCNT, 32'd0);
    check_val("rp_sync", {30'd0, oSYNC}, 32'd0);
    check_val("rp_busy_clr", {31'd0, oBUSY}, 32'd0);
    check_val("rp_ack", {31'd0, oLOAD_ACK}, 32'd0);
    ack_seen = 0;
    RST = 1'b0;
    tick();
    check_val("rp_start_noack", {31'd0, oLOAD_ACK}, 32'd0);
    check_val("rp_start_cnt", oCNT, 32'd0);
    wait_sync(0, 100, n); check_val("rp_s0", n, 32'd2);
    wait_sync(0, 100, n); check_val("rp_period", n, 32'd3);
    check_val("rp_never_ack", ack_seen, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_carrier_gen.md
Name: sync_carrier_gen

Overview:
Multi-channel synchronisation carrier generator for the PSM controller family. It produces CHANNELS phase-shifted sawtooth counters and one-cycle sync pulses, which drive the controller's iSych inputs. Period and per-channel phase are programmable at run time through a shadow-register load handshake. New settings take effect only at a master-period boundary, so carriers never glitch.

Parameters:
CHANNELS, 2, number of carrier channels (1..8).
BITS_DATA, 16, width of period, phase and counter values.

Ports:
CLK  in  1  system clock.
RST  in  1  reset, synchronous, active-high.
iEN  in  1  run enable; 0 holds all carriers in IDLE.
iFREQUENCY  in  BITS_DATA  requested period terminal count F; period is F+1 cycles.
iPHASE  in  CHANNELS*BITS_DATA  per-channel start offset; channel k is bits [k*BITS_DATA +: BITS_DATA].
iLOAD  in  1  one-cycle request to capture iFREQUENCY/iPHASE into shadow registers.
oLOAD_ACK  out  1  one-cycle pulse when shadow values become active.
oCNT  out  CHANNELS*BITS_DATA  per-channel carrier count.
oSYNC  out  CHANNELS  per-channel sync pulse.
oBUSY  out  1  high while a captured load is pending.

Behaviour:
- Reset: active F = 2, all phases = 0, all counters = 0. oSYNC = 0, oLOAD_ACK = 0, oBUSY = 0, state = IDLE. Shadow registers cleared, no load pending.
- FSM states:
  - IDLE: counters held at 0, oSYNC = 0. When iEN=1, go to RUN next cycle; each channel counter loads its active phase and the master counter loads 0. If a load is pending, it is applied on this start edge and oLOAD_ACK pulses.
  - RUN: on each cycle, every counter increments; a counter equal to F wraps to 0. iEN=0 returns to IDLE on the next cycle and counters clear. A pending load is retained across IDLE.
  - PENDING: same counting as RUN, with a load waiting. On the cycle the master counter equals F, all channels load from the shadow registers: F ← shadow F, channel k ← shadow phase k. oLOAD_ACK pulses on that edge and the FSM returns to RUN.
- iLOAD in any state captures the inputs into the shadow registers and sets oBUSY. If iLOAD arrives while PENDING, the last write wins and only one ack is issued. If iLOAD and the apply edge coincide, the old shadow values are applied and the new capture stays pending.
- oSYNC[k] is registered and high for exactly the cycle in which oCNT[k] == F, so it is aligned with oCNT.
- Width and range rules:
  - F below 2 is forced to 2.
  - A phase greater than F saturates to F.
  - All arithmetic is unsigned BITS_DATA; the wrap compare uses ==, with no modulo operator.
- RST asserted mid-period overrides everything within one edge; a pending load is lost.
- oBUSY clears on the same edge that oLOAD_ACK is registered high.

Optional Feature:
Macro SYNC_UPDOWN_EN.
- Defined: counters run centre-aligned. Each counts up 0→F, then down F→0, for a period of 2F cycles.
  - oSYNC[k] pulses at the peak (count F) while counting up.
  - The phase sets the initial count with direction up.
  - The load is applied when the master counter returns to 0.
  - Adds a per-channel direction bit.
- Not defined: sawtooth only, exactly as above; no direction logic is synthesised.

Decomposition:
- Package sync_carrier_pkg holds:
  - the FSM state enum (IDLE, RUN, PENDING);
  - constant MIN_PERIOD = 2;
  - default BITS_DATA;
  - a function to clamp a phase to F.
- Sub-module sync_phase_counter: one per channel, generated. It holds the counter, the optional direction bit, the terminal compare and the oSYNC register. Its inputs are load-value, load strobe, F and run.
- The top level holds the master counter, shadow registers, FSM and ack logic.

Test Plan:
- F=4000, phases {0,2000}, iEN=1 → oSYNC[0] every 4001 cycles, first pulse 4000 cycles after start; oSYNC[1] first pulse 2000 cycles after start, then every 4001 cycles.
- Running with F=4000, iLOAD with F=1000 at master count 100 → oBUSY=1, old period finishes; oLOAD_ACK on master==4000 edge; next periods 1001 cycles.
- Two iLOADs (F=500, then F=700) within one period → single ack; active F=700.
- iFREQUENCY=0, phase=9 → F forced to 2, phase saturated to 2; oSYNC pulses every 3 cycles starting on the first RUN cycle.
- RST pulse mid-PENDING → outputs 0, oBUSY=0, F=2, no ack ever issued for the lost load.
- SYNC_UPDOWN_EN defined, F=10, phase 0 → oCNT 0..10..0 triangle, oSYNC once per 20 cycles at count 10.
